// File: rtl/mode_guard_pkg.sv
// Shared types for the guarded mode FSM.
// Mode and state encodings plus the adjacency rule.
package mode_guard_pkg;

    typedef enum logic [1:0] {
        SAFE = 2'd0,
        LOW  = 2'd1,
        MID  = 2'd2,
        HIGH = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_SAFE = 3'd0,
        S_LOW  = 3'd1,
        S_MID  = 3'd2,
        S_HIGH = 3'd3,
        S_LOCK = 3'd4
    } guard_state_e;

    localparam int MODE_VALID_BIT = 2;

    // Widen before +/-1 so HIGH never wraps around to SAFE.
    function automatic logic is_adjacent(input mode_e cur, input mode_e tgt);
        logic [2:0] c;
        logic [2:0] t;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        return (t == c + 3'd1) || (c == t + 3'd1);
    endfunction

endpackage

// File: rtl/mode_guard_dwell_timer.sv
// Reusable dwell down-counter: load, clear, registered busy flag.
// Named mode_dwell_timer; clear has priority over load.
module mode_dwell_timer
    import mode_guard_pkg::*;
#(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_clear,
    output logic o_busy
);

    localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_busy;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clear) begin
            w_cnt_next = '0;
        end else if (i_load) begin
            w_cnt_next = CW'(CYCLES);
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_busy <= (w_cnt_next != '0);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/mode_transition_guard.sv
// Hardened mode FSM: adjacent steps, dwell time, illegal-request lockout.
// Unused state encodings fall into LOCK.
module mode_transition_guard
    import mode_guard_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int ERR_LIMIT    = 3,
    parameter int ERR_W        = $clog2(ERR_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req_code,
    input  logic             unlock_i,
    output logic [1:0]       mode_o,
    output logic             mode_valid_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             lockout_o
);

    guard_state_e     r_state;
    guard_state_e     w_next;
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_next;
    logic [ERR_W-1:0] w_err_inc;
    logic [1:0]       r_mode;
    logic             r_mode_valid;
    logic             r_illegal;
    logic             r_lock;
    logic             w_illegal;
    logic             w_load;
    logic             w_clear;
    logic             w_busy;
    logic             w_req_v;
    mode_e            w_cur;
    mode_e            w_tgt;

    assign w_req_v   = req_code[MODE_VALID_BIT];
    assign w_cur     = mode_e'(r_state[1:0]);
    assign w_tgt     = mode_e'(req_code[1:0]);
    assign w_err_inc = r_err + ERR_W'(1);

    always_comb begin
        w_next     = r_state;
        w_err_next = r_err;
        w_illegal  = 1'b0;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            S_SAFE, S_LOW, S_MID, S_HIGH: begin
                if (w_req_v && (w_tgt != w_cur)) begin
                    if (w_tgt == SAFE) begin
                        w_next  = S_SAFE;
                        w_clear = 1'b1;
                    end else if (w_busy) begin
                        w_next = r_state;
                    end else if (is_adjacent(w_cur, w_tgt)) begin
                        w_next = guard_state_e'({1'b0, w_tgt});
                        w_load = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                        if (r_err < ERR_W'(ERR_LIMIT)) begin
                            w_err_next = w_err_inc;
                        end
                        if (w_err_inc >= ERR_W'(ERR_LIMIT)) begin
                            w_next  = S_LOCK;
                            w_clear = 1'b1;
                        end
                    end
                end
            end
            S_LOCK: begin
                if (unlock_i) begin
                    w_next     = S_SAFE;
                    w_err_next = '0;
                    w_clear    = 1'b1;
                end
            end
            default: begin
                w_next  = S_LOCK;
                w_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_SAFE;
            r_err        <= '0;
            r_mode       <= 2'd0;
            r_mode_valid <= 1'b1;
            r_illegal    <= 1'b0;
            r_lock       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_err        <= w_err_next;
            r_illegal    <= w_illegal;
            r_lock       <= (w_next == S_LOCK);
            r_mode_valid <= (w_next != S_LOCK);
            r_mode       <= (w_next == S_LOCK) ? 2'd0 : w_next[1:0];
        end
    end

    mode_dwell_timer #(
        .CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .o_busy  (w_busy)
    );

    assign mode_o       = r_mode;
    assign mode_valid_o = r_mode_valid;
    assign busy_o       = w_busy;
    assign illegal_o    = r_illegal;
    assign err_cnt_o    = r_err;
    assign lockout_o    = r_lock;

endmodule
